rv32_mc_control: RTL

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory access and write-back over the shared ALU, register file, PC/IR registers and a single memory port. Each cycle it drives the datapath steering, write-enable and `alu_ctrl` signals. It decodes the IR fields as the 11-bit key `{instr[30], funct3, opcode}`.

---
 rtl/rv32_mc_control.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32_mc_control.sv
// rv32_mc_control: multi-cycle RV32I control FSM; RV32_MC_ILLEGAL_TRAP_EN sends illegal opcodes to a sticky TRAP
module rv32_mc_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        ir_write,
    output logic        pc_write,
    output logic        tgt_write,
    output logic        reg_write,
    output logic        pc_init,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef RV32_MC_ILLEGAL_TRAP_EN
    localparam state_t ILL_NX = S_TRAP;
`else
    localparam state_t ILL_NX = S_FETCH;
`endif

    state_t      st, st_nx;
    logic [10:0] key;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rd_nz, legal, taken, is_load;
    logic [3:0]  alu_op;
    logic        unused_bits;

    assign key         = {instr[30], instr[14:12], instr[6:0]};
    assign op          = key[6:0];
    assign f3          = key[9:7];
    assign rd_nz       = instr[11:7] != 5'd0;
    assign is_load     = op == OP_LD;
    assign state       = st;
    assign unused_bits = ^{RESET_PC, instr[31], instr[29:15]};

    // Opcode legality and branch condition from the ALU flags
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_BR: legal = f3[2:1] != 2'b01;
            default: legal = 1'b0;
        endcase
        taken = (f3[2] ? (f3[1] ? ltu : lt) : zero) ^ f3[0];
    end

    // ALU operation for R/I arithmetic; bit 30 only selects sub (R-type) and sra
    always_comb begin
        alu_op = 4'd0;
        case (f3)
            3'd0: alu_op = (key[10] && op == OP_R) ? 4'd1 : 4'd0;
            3'd1: alu_op = 4'd7;
            3'd2: alu_op = 4'd4;
            3'd3: alu_op = 4'd5;
            3'd4: alu_op = 4'd6;
            3'd5: alu_op = key[10] ? 4'd9 : 4'd8;
            3'd6: alu_op = 4'd2;
            default: alu_op = 4'd3;
        endcase
    end

    // State register; reset drops any in-flight memory request immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) st <= S_RESET;
        else          st <= st_nx;
    end

`ifdef RV32_MC_ILLEGAL_TRAP_EN
    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                     illegal <= 1'b0;
        else if (st == S_DECODE && !legal) illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    // Next-state and datapath control decode
    always_comb begin
        st_nx     = st;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_size  = 2'd0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        tgt_write = 1'b0;
        reg_write = 1'b0;
        pc_init   = 1'b0;
        alu_ctrl  = 4'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        pc_src    = 2'd0;
        wb_sel    = 2'd0;
        case (st)
            S_RESET: begin
                pc_init = 1'b1;
                st_nx   = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_size  = 2'd2;
                alu_src_b = 2'd2;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                st_nx     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'd1;
                tgt_write = 1'b1;
                st_nx     = legal ? S_EXEC : ILL_NX;
            end
            S_EXEC: begin
                st_nx = S_FETCH;
                case (op)
                    OP_R: begin
                        alu_src_a = 2'd1;
                        alu_ctrl  = alu_op;
                        st_nx     = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        alu_ctrl  = alu_op;
                        st_nx     = S_WB;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                        alu_ctrl  = 4'd10;
                        st_nx     = S_WB;
                    end
                    OP_AUIPC: st_nx = S_WB;
                    OP_LD, OP_ST: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        st_nx     = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a = 2'd1;
                        alu_ctrl  = 4'd1;
                        pc_write  = taken;
                        pc_src    = 2'd1;
                    end
                    OP_JAL: begin
                        reg_write = rd_nz;
                        wb_sel    = 2'd2;
                        pc_write  = 1'b1;
                        pc_src    = 2'd1;
                    end
                    OP_JALR: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = rd_nz;
                        wb_sel    = 2'd2;
                    end
                    default: st_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = op == OP_ST;
                mem_size = f3[1:0];
                st_nx    = mem_ready ? (is_load ? S_WB : S_FETCH) : S_MEM;
            end
            S_WB: begin
                reg_write = rd_nz;
                wb_sel    = is_load ? 2'd1 : 2'd0;
                st_nx     = S_FETCH;
            end
            default: st_nx = st;
        endcase
    end
endmodule
